// File: rtl/mux_select_scanner.sv
// mux_select_scanner: round-robin 8-way select generator with fixed dwell (MUX_SELECT_SCANNER_FIXED_PRIORITY_EN selects fixed priority)
module mux_select_scanner #(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] req,
    output logic [2:0] sel,
    output logic [7:0] grant,
    output logic       valid,
    output logic       done
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] last, last_n, sel_n, pick;
    logic [7:0] grant_n;
    logic load;
    assign valid = state == HOLD;
    assign done  = valid && cnt == '0;
    assign load  = en && |req && (state == IDLE || cnt == '0);
    // winner search; later loop iterations override, so the nearest candidate wins
    always_comb begin
        pick = '0;
`ifdef MUX_SELECT_SCANNER_FIXED_PRIORITY_EN
        for (int k = 7; k >= 0; k--)
            if (req[k]) pick = 3'(k);
`else
        for (int k = 8; k >= 1; k--)
            if (req[last + 3'(k)]) pick = last + 3'(k);
`endif
    end
    // next state: count down the dwell, reload back-to-back at its end, else drop to idle
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sel_n   = sel;
        grant_n = grant;
        last_n  = last;
        if (state == HOLD && cnt != '0) begin
            cnt_n = cnt - 1'b1;
        end else if (load) begin
            state_n = HOLD;
            sel_n   = pick;
            grant_n = 8'b1 << pick;
            last_n  = pick;
            cnt_n   = CW'(DWELL - 1);
        end else begin
            state_n = IDLE;
            grant_n = '0;
        end
    end
    // state register with asynchronous reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            sel   <= '0;
            grant <= '0;
            last  <= 3'd7;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sel   <= sel_n;
            grant <= grant_n;
            last  <= last_n;
        end
    end
endmodule

// File: tb/tb_mux_select_scanner.sv
// tb_mux_select_scanner: directed bench for mux_select_scanner (DWELL=4 and DWELL=1 instances)
module tb_mux_select_scanner;
`ifdef MUX_SELECT_SCANNER_FIXED_PRIORITY_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif
    logic clk, reset, en, en1;
    logic [7:0] req, req1, grant, grant1;
    logic [2:0] sel, sel1;
    logic valid, done, valid1, done1;
    int checks = 0;
    int errors = 0;

    mux_select_scanner #(.DWELL(4), .CW(8)) dut (
        .clk(clk), .reset(reset), .en(en), .req(req),
        .sel(sel), .grant(grant), .valid(valid), .done(done)
    );
    mux_select_scanner #(.DWELL(1), .CW(8)) dut1 (
        .clk(clk), .reset(reset), .en(en1), .req(req1),
        .sel(sel1), .grant(grant1), .valid(valid1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect4(input string t, input int s, input int g, input int v, input int d);
        check({t, ".sel"}, int'(sel), s);
        check({t, ".grant"}, int'(grant), g);
        check({t, ".valid"}, int'(valid), v);
        check({t, ".done"}, int'(done), d);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        int s;
        reset = 1'b1; en = 1'b0; req = '0; en1 = 1'b0; req1 = '0;
        step();
        expect4("rst", 0, 0, 0, 0);
        check("rst1.valid", int'(valid1), 0);
        check("rst1.sel", int'(sel1), 0);
        reset = 1'b0;
        step();
        expect4("idle", 0, 0, 0, 0);
        // two requesters, back-to-back grants
        en = 1'b1; req = 8'b0000_0101;
        for (int c = 1; c <= 9; c++) begin
            step();
            s = FP ? 0 : ((c > 4 && c <= 8) ? 2 : 0);
            expect4($sformatf("rr%0d", c), s, 1 << s, 1, (c % 4 == 0) ? 1 : 0);
        end
        // pointer wrap 7 -> 0
        req = 8'b1000_0001;
        for (int c = 10; c <= 12; c++) begin
            step();
            expect4($sformatf("wrap%0d", c), 0, 1, 1, c == 12 ? 1 : 0);
        end
        step();
        s = FP ? 0 : 7;
        expect4("wrap13", s, 1 << s, 1, 0);
        for (int c = 14; c <= 16; c++) begin
            step();
            expect4($sformatf("wrap%0d", c), s, 1 << s, 1, c == 16 ? 1 : 0);
        end
        step();
        expect4("wrap17", 0, 1, 1, 0);
        // one-cycle request pulse, no preemption
        req = '0;
        step(); step(); step();
        expect4("drain", 0, 1, 1, 1);
        step();
        expect4("idle2", 0, 0, 0, 0);
        req = 8'h10;
        for (int c = 1; c <= 4; c++) begin
            step();
            req = '0;
            expect4($sformatf("pulse%0d", c), 4, 8'h10, 1, c == 4 ? 1 : 0);
        end
        step();
        expect4("pulse_idle", 4, 0, 0, 0);
        step();
        expect4("pulse_stay", 4, 0, 0, 0);
        // en dropped mid-dwell
        req = 8'h08;
        step();
        expect4("en1", 3, 8'h08, 1, 0);
        req = 8'hFF; en = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            step();
            expect4($sformatf("en%0d", c), 3, 8'h08, 1, c == 4 ? 1 : 0);
        end
        step();
        expect4("en_idle", 3, 0, 0, 0);
        en = 1'b1;
        step();
        s = FP ? 0 : 4;
        expect4("en_re", s, 1 << s, 1, 0);
        // asynchronous reset mid-dwell
        en = 1'b0; req = '0;
        step(); step(); step(); step();
        check("pre5.valid", int'(valid), 0);
        en = 1'b1; req = 8'h20;
        step();
        expect4("ch5_1", 5, 8'h20, 1, 0);
        step(); step();
        expect4("ch5_3", 5, 8'h20, 1, 0);
        reset = 1'b1;
        #1;
        expect4("arst", 0, 0, 0, 0);
        step();
        expect4("arst_hold", 0, 0, 0, 0);
        reset = 1'b0;
        step();
        expect4("after_rst", 5, 8'h20, 1, 0);
        en = 1'b0; req = '0;
        // DWELL = 1, all requesting
        en1 = 1'b1; req1 = 8'hFF;
        for (int i = 0; i <= 8; i++) begin
            step();
            s = FP ? 0 : i % 8;
            check($sformatf("d1_%0d.sel", i), int'(sel1), s);
            check($sformatf("d1_%0d.grant", i), int'(grant1), 1 << s);
            check($sformatf("d1_%0d.valid", i), int'(valid1), 1);
            check($sformatf("d1_%0d.done", i), int'(done1), 1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
